reg_to_axi_master: RTL and testbench
====================================

# reg_to_axi_master

Single-outstanding AXI master that turns a simple register-style command port into single-beat, 32-bit AXI4 read and write transactions. It is the initiator counterpart to our AXI register-bridge slaves. Typical uses are a small sequencer or test controller driving a fabric of AXI register slaves, including loopback against our own bridge in simulation. Exactly one transaction is in flight at a time; there is no burst support.

## Interface
Parameters:
- ID, 0: value driven on awid/arid; also the value expected on bid/rid.

Ports:
- clk  in  1  clock; all logic is on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- m  axi_ifc.master  —  AXI4 master port. Uses the aw, w, b, ar and r channels.
- i_req  in  1  command strobe; sampled only while o_busy=0.
- i_write  in  1  1 = write, 0 = read; sampled with i_req.
- i_addr  in  32  byte address; sampled with i_req.
- i_wdata  in  32  write data; sampled with i_req.
- o_busy  out  1  a transaction is in progress.
- o_done  out  1  one-cycle completion pulse.
- o_rdata  out  32  read data; valid with o_done and held until the next o_done.
- o_resp  out  2  completion response; valid with o_done and held.

## Operation
- Constant AXI fields:
  - awlen = arlen = 0; awsize = arsize = 3'b010; awburst = arburst = 2'b01.
  - wstrb = 4'hF; wlast = 1; awid = arid = ID.
- Addresses: awaddr/araddr = {i_addr[31:2], 2'b00}, latched at accept.
- Write data: wdata = the latched i_wdata.
- States: IDLE, WRITE, W_RESP, READ, R_DATA.
- IDLE:
  - i_req=1 latches the command, sets o_busy=1 and moves to WRITE or READ.
  - i_req while o_busy=1 is ignored. Commands are not queued.
- WRITE:
  - awvalid and wvalid assert together.
  - Each one drops the cycle after its own handshake (valid & ready).
  - The state moves to W_RESP once both handshakes have completed, in either order or in the same cycle.
  - awaddr/wdata stay stable while the corresponding valid is high.
- W_RESP:
  - bready=1.
  - On bvalid the state returns to IDLE, o_done pulses and o_resp takes bresp.
  - If bid≠ID, o_resp is forced to 2'b10.
- READ:
  - arvalid=1 until the ar handshake, then the state moves to R_DATA.
- R_DATA:
  - rready=1.
  - On rvalid the block captures rdata into o_rdata and rresp into o_resp (forced to 2'b10 if rid≠ID), pulses o_done and returns to IDLE.
  - rlast is ignored.
- Writes leave o_rdata unchanged.
- All AXI outputs and all command-side outputs are registered. No combinational path exists from any AXI input to any AXI output.

## Timing
- Reset values (rst_n=0, asynchronous; a reset mid-transaction aborts it immediately):
  - awvalid, wvalid, arvalid, bready, rready, o_busy, o_done = 0.
  - o_rdata = 0, o_resp = 0, awaddr/araddr/wdata = 0, state = IDLE.
- Accept edge:
  - i_req sampled high at edge N (o_busy=0) gives o_busy=1 and awvalid/wvalid (or arvalid) = 1 after edge N.
- Valid deassertion:
  - A handshake at edge M drops that valid after edge M.
  - bready/rready rise the cycle after the last address/data handshake.
- Completion:
  - A B/R handshake at edge K gives o_done=1 and o_busy=0 after edge K, with o_rdata/o_resp updated at the same edge.
- Zero-wait-state slave latencies (request edge to o_done):
  - Write: 3 cycles.
  - Read: 3 cycles.
- Back-to-back: i_req may be high again in the o_done cycle; it is accepted at that edge.
- No timeout. A slave that never responds holds o_busy=1 until reset.

## Test plan
- Write, zero-wait slave: i_write=1, i_addr=32'h0010_0008, i_wdata=32'hDEADBEEF → awaddr=32'h0010_0008, wdata=32'hDEADBEEF, wstrb=4'hF, wlast=1; o_done 3 cycles after request; o_resp=0.
- Read with stalls: i_addr=32'h0020_0004, arready delayed 4 cycles, rvalid delayed 2 cycles with rdata=32'h1234_5678 → arvalid stays high with stable araddr until the handshake; o_rdata=32'h1234_5678; o_done is a single pulse.
- Split aw/w acceptance: wready 3 cycles before awready, then the reverse order → each valid drops independently; bready is not asserted until both are done; exactly one o_done.
- Responses: bresp=2'b10 gives o_resp=2'b10; with ID=3, rid=1 and rresp=0 gives o_resp=2'b10; i_addr=32'h...0007 gives awaddr[1:0]=0.
- Back-to-back plus ignored request: a write followed by a read with i_req held high through the o_done cycle → the read is accepted at that edge. A pulse on i_req mid-transaction produces no extra transaction.
- Reset mid-write: rst_n low while awvalid=1 → all valids and readies drop asynchronously and o_busy=0; after release, a new read completes normally.

Source files
------------

// File: rtl/reg_to_axi_master.sv
// Single-outstanding AXI4 master: turns a register-style command strobe into one
// single-beat 32-bit write or read, reporting completion with a one-cycle o_done.
module reg_to_axi_master #(
  parameter int unsigned     ID_W = 4,
  parameter logic [ID_W-1:0] ID   = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_req,
  input  logic            i_write,
  input  logic [31:0]     i_addr,
  input  logic [31:0]     i_wdata,
  output logic            o_busy,
  output logic            o_done,
  output logic [31:0]     o_rdata,
  output logic [1:0]      o_resp,
  output logic [ID_W-1:0] m_awid_o,
  output logic [31:0]     m_awaddr_o,
  output logic [7:0]      m_awlen_o,
  output logic [2:0]      m_awsize_o,
  output logic [1:0]      m_awburst_o,
  output logic            m_awvalid_o,
  input  logic            m_awready_i,
  output logic [31:0]     m_wdata_o,
  output logic [3:0]      m_wstrb_o,
  output logic            m_wlast_o,
  output logic            m_wvalid_o,
  input  logic            m_wready_i,
  input  logic [ID_W-1:0] m_bid_i,
  input  logic [1:0]      m_bresp_i,
  input  logic            m_bvalid_i,
  output logic            m_bready_o,
  output logic [ID_W-1:0] m_arid_o,
  output logic [31:0]     m_araddr_o,
  output logic [7:0]      m_arlen_o,
  output logic [2:0]      m_arsize_o,
  output logic [1:0]      m_arburst_o,
  output logic            m_arvalid_o,
  input  logic            m_arready_i,
  input  logic [ID_W-1:0] m_rid_i,
  input  logic [31:0]     m_rdata_i,
  input  logic [1:0]      m_rresp_i,
  input  logic            m_rlast_i,
  input  logic            m_rvalid_i,
  output logic            m_rready_o
);

  typedef enum logic [2:0] {IDLE, WRITE, W_RESP, READ, R_DATA} state_e;

  state_e      state_q, state_d;
  logic        awvalid_q, awvalid_d, wvalid_q, wvalid_d, arvalid_q, arvalid_d;
  logic        bready_q, bready_d, rready_q, rready_d;
  logic        busy_q, busy_d, done_q, done_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;
  logic [1:0]  resp_q, resp_d;

  // Single-beat transfers only: rlast and the byte offset carry no information.
  logic unused_inputs;
  assign unused_inputs = ^{m_rlast_i, i_addr[1:0]};

  always_comb begin
    state_d   = state_q;
    awvalid_d = awvalid_q;
    wvalid_d  = wvalid_q;
    arvalid_d = arvalid_q;
    bready_d  = bready_q;
    rready_d  = rready_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    resp_d    = resp_q;
    case (state_q)
      IDLE: begin
        if (i_req) begin
          addr_d = {i_addr[31:2], 2'b00};
          busy_d = 1'b1;
          if (i_write) begin
            wdata_d   = i_wdata;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            state_d   = WRITE;
          end else begin
            arvalid_d = 1'b1;
            state_d   = READ;
          end
        end
      end
      WRITE: begin
        // AW and W complete independently; the response phase waits for both.
        awvalid_d = awvalid_q & ~m_awready_i;
        wvalid_d  = wvalid_q & ~m_wready_i;
        if (!awvalid_d && !wvalid_d) begin
          bready_d = 1'b1;
          state_d  = W_RESP;
        end
      end
      W_RESP: begin
        if (m_bvalid_i) begin
          bready_d = 1'b0;
          busy_d   = 1'b0;
          done_d   = 1'b1;
          resp_d   = (m_bid_i == ID) ? m_bresp_i : 2'b10;
          state_d  = IDLE;
        end
      end
      READ: begin
        if (m_arready_i) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = R_DATA;
        end
      end
      R_DATA: begin
        if (m_rvalid_i) begin
          rready_d = 1'b0;
          busy_d   = 1'b0;
          done_d   = 1'b1;
          rdata_d  = m_rdata_i;
          resp_d   = (m_rid_i == ID) ? m_rresp_i : 2'b10;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      arvalid_q <= 1'b0;
      bready_q  <= 1'b0;
      rready_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      resp_q    <= '0;
    end else begin
      state_q   <= state_d;
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      arvalid_q <= arvalid_d;
      bready_q  <= bready_d;
      rready_q  <= rready_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      resp_q    <= resp_d;
    end
  end

  assign o_busy      = busy_q;
  assign o_done      = done_q;
  assign o_rdata     = rdata_q;
  assign o_resp      = resp_q;
  assign m_awid_o    = ID;
  assign m_awaddr_o  = addr_q;
  assign m_awlen_o   = 8'd0;
  assign m_awsize_o  = 3'b010;
  assign m_awburst_o = 2'b01;
  assign m_awvalid_o = awvalid_q;
  assign m_wdata_o   = wdata_q;
  assign m_wstrb_o   = 4'hF;
  assign m_wlast_o   = 1'b1;
  assign m_wvalid_o  = wvalid_q;
  assign m_bready_o  = bready_q;
  assign m_arid_o    = ID;
  assign m_araddr_o  = addr_q;
  assign m_arlen_o   = 8'd0;
  assign m_arsize_o  = 3'b010;
  assign m_arburst_o = 2'b01;
  assign m_arvalid_o = arvalid_q;
  assign m_rready_o  = rready_q;

endmodule

// File: tb/tb_reg_to_axi_master.sv
// Bench for reg_to_axi_master: a delay-programmable AXI slave plus a reference
// model of latency, response, address and read-data behaviour.
module tb_reg_to_axi_master;

  localparam logic [3:0] TID  = 4'd3;
  localparam int         MAXC = 200;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_req, i_write;
  logic [31:0] i_addr, i_wdata;
  logic        o_busy, o_done;
  logic [31:0] o_rdata;
  logic [1:0]  o_resp;
  logic [3:0]  awid, arid, bid, rid;
  logic [31:0] awaddr, araddr, wdata, rdata;
  logic [7:0]  awlen, arlen;
  logic [2:0]  awsize, arsize;
  logic [1:0]  awburst, arburst, bresp, rresp;
  logic [3:0]  wstrb;
  logic        wlast, awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready, rlast;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_rdata;

  always #5 clk = ~clk;

  reg_to_axi_master #(.ID_W(4), .ID(TID)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req(i_req), .i_write(i_write), .i_addr(i_addr), .i_wdata(i_wdata),
    .o_busy(o_busy), .o_done(o_done), .o_rdata(o_rdata), .o_resp(o_resp),
    .m_awid_o(awid), .m_awaddr_o(awaddr), .m_awlen_o(awlen), .m_awsize_o(awsize),
    .m_awburst_o(awburst), .m_awvalid_o(awvalid), .m_awready_i(awready),
    .m_wdata_o(wdata), .m_wstrb_o(wstrb), .m_wlast_o(wlast), .m_wvalid_o(wvalid),
    .m_wready_i(wready),
    .m_bid_i(bid), .m_bresp_i(bresp), .m_bvalid_i(bvalid), .m_bready_o(bready),
    .m_arid_o(arid), .m_araddr_o(araddr), .m_arlen_o(arlen), .m_arsize_o(arsize),
    .m_arburst_o(arburst), .m_arvalid_o(arvalid), .m_arready_i(arready),
    .m_rid_i(rid), .m_rdata_i(rdata), .m_rresp_i(rresp), .m_rlast_i(rlast),
    .m_rvalid_i(rvalid), .m_rready_o(rready)
  );

  task automatic slave_idle();
    awready = 1'b0; wready = 1'b0; arready = 1'b0;
    bvalid = 1'b0; rvalid = 1'b0;
    bid = '0; bresp = '0; rid = '0; rdata = '0; rresp = '0; rlast = 1'b0;
  endtask

  // Issues one command at the current negedge and plays the slave until o_done.
  // Protocol violations seen along the way are tallied in viol.
  task automatic run_txn(
    input bit wr, input logic [31:0] addr, input logic [31:0] wd,
    input int awd, input int wdd, input int bd, input int ard, input int rd,
    input logic [1:0] sresp, input logic [3:0] sid, input logic [31:0] srdata,
    input bit keep_req, input bit nxt_wr, input logic [31:0] nxt_addr, input int pulse_at,
    output int lat, output int ndone, output int viol,
    output logic [31:0] seen_addr, output logic [31:0] seen_wdata,
    output logic [31:0] got_rdata, output logic [1:0] got_resp);
    int aw_cnt, w_cnt, ar_cnt, b_cnt, r_cnt;
    bit aw_hs, w_hs, ar_hs, resp_hs, both, finished;
    aw_cnt = 0; w_cnt = 0; ar_cnt = 0; b_cnt = 0; r_cnt = 0;
    aw_hs = 0; w_hs = 0; ar_hs = 0; resp_hs = 0; finished = 0;
    lat = -1; ndone = 0; viol = 0;
    seen_addr = '0; seen_wdata = '0; got_rdata = '0; got_resp = '0;
    i_req = 1'b1; i_write = wr; i_addr = addr; i_wdata = wd;
    for (int cyc = 1; cyc <= MAXC && !finished; cyc++) begin
      @(negedge clk);
      if (cyc == 1) begin
        if (keep_req) begin i_write = nxt_wr; i_addr = nxt_addr; end
        else i_req = 1'b0;
        if (!o_busy) viol++;
        if (wr ? !(awvalid && wvalid) : !arvalid) viol++;
        seen_addr  = wr ? awaddr : araddr;
        seen_wdata = wdata;
        if (wr && (wstrb !== 4'hF || wlast !== 1'b1 || awlen !== 8'd0 ||
                   awsize !== 3'b010 || awburst !== 2'b01 || awid !== TID)) viol++;
        if (!wr && (arlen !== 8'd0 || arsize !== 3'b010 || arburst !== 2'b01 ||
                    arid !== TID)) viol++;
      end
      if (pulse_at > 0 && cyc == pulse_at) begin
        i_req = 1'b1; i_write = ~wr; i_addr = $urandom;
      end else if (pulse_at > 0 && cyc == pulse_at + 1) begin
        i_req = 1'b0;
      end
      if (o_done) begin
        ndone++;
        if (lat < 0) begin lat = cyc; got_rdata = o_rdata; got_resp = o_resp; end
        if (o_busy || bready || rready) viol++;
        finished = 1;
      end
      if (wr) begin
        if (aw_hs ? awvalid : !awvalid) viol++;
        if (w_hs ? wvalid : !wvalid) viol++;
        if (awvalid && awaddr !== seen_addr) viol++;
        if (wvalid && wdata !== seen_wdata) viol++;
        if (bready && !(aw_hs && w_hs)) viol++;
        if (arvalid || rready) viol++;
      end else begin
        if (ar_hs ? arvalid : !arvalid) viol++;
        if (arvalid && araddr !== seen_addr) viol++;
        if (rready && !ar_hs) viol++;
        if (awvalid || wvalid || bready) viol++;
      end
      if (finished) break;
      both = aw_hs && w_hs;
      awready = 1'b0; wready = 1'b0; arready = 1'b0;
      if (awvalid && !aw_hs) begin
        if (aw_cnt >= awd) begin awready = 1'b1; aw_hs = 1; end
        aw_cnt++;
      end
      if (wvalid && !w_hs) begin
        if (w_cnt >= wdd) begin wready = 1'b1; w_hs = 1; end
        w_cnt++;
      end
      if (wr && both && !resp_hs) begin
        bid = sid; bresp = sresp;
        if (b_cnt >= bd) bvalid = 1'b1;
        b_cnt++;
        if (bvalid && bready) resp_hs = 1;
      end
      if (arvalid && !ar_hs && !wr) begin
        if (ar_cnt >= ard) begin arready = 1'b1; ar_hs = 1; end
        ar_cnt++;
      end else if (!wr && ar_hs && !arready && !resp_hs) begin
        rid = sid; rresp = sresp; rdata = srdata; rlast = 1'($urandom);
        if (r_cnt >= rd) rvalid = 1'b1;
        r_cnt++;
        if (rvalid && rready) resp_hs = 1;
      end
      if (!wr && resp_hs && !rvalid) viol++;
    end
    slave_idle();
    if (!finished) viol++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    i_req = 1'b0; i_write = 1'b0; i_addr = '0; i_wdata = '0;
    slave_idle();
    repeat (2) @(negedge clk);
    checks++;
    if ({awvalid, wvalid, arvalid, bready, rready, o_busy, o_done} !== 7'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got %b expected 0", {awvalid, wvalid, arvalid, bready, rready, o_busy, o_done});
    end
    checks++;
    if ({o_rdata, o_resp} !== 34'b0) begin
      errors++; $display("FAIL reset_out: rdata %h resp %b expected 0", o_rdata, o_resp);
    end
    checks++;
    if ({awaddr, araddr, wdata} !== 96'b0) begin
      errors++; $display("FAIL reset_bus: aw %h ar %h w %h expected 0", awaddr, araddr, wdata);
    end
    rst_n = 1'b1;
    exp_rdata = '0;
    @(negedge clk);
  endtask

  task automatic test_write_zero_wait();
    int lat, nd, vi; logic [31:0] sa, sw, gr; logic [1:0] gs;
    run_txn(1, 32'h0010_0008, 32'hDEADBEEF, 0, 0, 0, 0, 0, 2'b00, TID, '0,
            0, 0, '0, 0, lat, nd, vi, sa, sw, gr, gs);
    checks++; if (lat !== 3) begin errors++; $display("FAIL wr_lat: got %0d expected 3", lat); end
    checks++; if (sa !== 32'h0010_0008) begin errors++; $display("FAIL wr_awaddr: got %h expected 00100008", sa); end
    checks++; if (sw !== 32'hDEADBEEF) begin errors++; $display("FAIL wr_wdata: got %h expected deadbeef", sw); end
    checks++; if (gs !== 2'b00) begin errors++; $display("FAIL wr_resp: got %b expected 00", gs); end
    checks++; if (vi !== 0) begin errors++; $display("FAIL wr_proto: got %0d violations expected 0", vi); end
  endtask

  task automatic test_read_stall();
    int lat, nd, vi; logic [31:0] sa, sw, gr; logic [1:0] gs;
    run_txn(0, 32'h0020_0004, '0, 0, 0, 0, 4, 2, 2'b00, TID, 32'h1234_5678,
            0, 0, '0, 0, lat, nd, vi, sa, sw, gr, gs);
    exp_rdata = 32'h1234_5678;
    checks++; if (lat !== 9) begin errors++; $display("FAIL rd_lat: got %0d expected 9", lat); end
    checks++; if (sa !== 32'h0020_0004) begin errors++; $display("FAIL rd_araddr: got %h expected 00200004", sa); end
    checks++; if (gr !== 32'h1234_5678) begin errors++; $display("FAIL rd_data: got %h expected 12345678", gr); end
    checks++; if (vi !== 0) begin errors++; $display("FAIL rd_proto: got %0d violations expected 0", vi); end
    @(negedge clk);
    checks++; if (o_done !== 1'b0) begin errors++; $display("FAIL rd_done_pulse: got %b expected 0", o_done); end
    checks++; if (o_rdata !== 32'h1234_5678) begin errors++; $display("FAIL rd_hold: got %h expected 12345678", o_rdata); end
  endtask

  task automatic test_split_aw_w();
    int lat, nd, vi; logic [31:0] sa, sw, gr; logic [1:0] gs;
    for (int k = 0; k < 2; k++) begin
      run_txn(1, 32'h0000_1000 + 32'(k * 4), 32'hA5A5_0000 + 32'(k), (k == 0) ? 3 : 0, (k == 0) ? 0 : 3,
              0, 0, 0, 2'b00, TID, '0, 0, 0, '0, 0, lat, nd, vi, sa, sw, gr, gs);
      checks++; if (lat !== 6) begin errors++; $display("FAIL split%0d_lat: got %0d expected 6", k, lat); end
      checks++; if (vi !== 0) begin errors++; $display("FAIL split%0d_proto: got %0d violations expected 0", k, vi); end
      @(negedge clk);
      checks++; if (o_done !== 1'b0) begin errors++; $display("FAIL split%0d_one_done: got %b expected 0", k, o_done); end
    end
  endtask

  task automatic test_responses();
    int lat, nd, vi; logic [31:0] sa, sw, gr; logic [1:0] gs;
    run_txn(1, 32'h0000_0040, 32'h1, 0, 0, 0, 0, 0, 2'b10, TID, '0,
            0, 0, '0, 0, lat, nd, vi, sa, sw, gr, gs);
    checks++; if (gs !== 2'b10) begin errors++; $display("FAIL bresp_slverr: got %b expected 10", gs); end
    checks++; if (gr !== exp_rdata) begin errors++; $display("FAIL wr_keeps_rdata: got %h expected %h", gr, exp_rdata); end
    run_txn(0, 32'h0000_0044, '0, 0, 0, 0, 1, 1, 2'b00, 4'd1, 32'hCAFE_F00D,
            0, 0, '0, 0, lat, nd, vi, sa, sw, gr, gs);
    exp_rdata = 32'hCAFE_F00D;
    checks++; if (gs !== 2'b10) begin errors++; $display("FAIL rid_mismatch: got %b expected 10", gs); end
    run_txn(1, 32'h0000_0048, '0, 0, 0, 0, 0, 0, 2'b00, 4'd7, '0,
            0, 0, '0, 0, lat, nd, vi, sa, sw, gr, gs);
    checks++; if (gs !== 2'b10) begin errors++; $display("FAIL bid_mismatch: got %b expected 10", gs); end
    run_txn(1, 32'h0030_0007, 32'h77, 0, 0, 0, 0, 0, 2'b01, TID, '0,
            0, 0, '0, 0, lat, nd, vi, sa, sw, gr, gs);
    checks++; if (sa !== 32'h0030_0004) begin errors++; $display("FAIL addr_align: got %h expected 00300004", sa); end
    checks++; if (gs !== 2'b01) begin errors++; $display("FAIL bresp_pass: got %b expected 01", gs); end
  endtask

  task automatic test_back_to_back();
    int lat, nd, vi; logic [31:0] sa, sw, gr; logic [1:0] gs;
    run_txn(1, 32'h0000_0100, 32'h0BAD_0001, 1, 2, 1, 0, 0, 2'b00, TID, '0,
            1, 0, 32'h0000_0200, 0, lat, nd, vi, sa, sw, gr, gs);
    checks++; if (lat !== 6) begin errors++; $display("FAIL b2b_wr_lat: got %0d expected 6", lat); end
    run_txn(0, 32'h0000_0200, '0, 0, 0, 0, 0, 0, 2'b00, TID, 32'h5EED_0002,
            0, 0, '0, 0, lat, nd, vi, sa, sw, gr, gs);
    exp_rdata = 32'h5EED_0002;
    checks++; if (lat !== 3) begin errors++; $display("FAIL b2b_rd_lat: got %0d expected 3", lat); end
    checks++; if (gr !== 32'h5EED_0002) begin errors++; $display("FAIL b2b_rd_data: got %h expected 5eed0002", gr); end
    run_txn(1, 32'h0000_0300, 32'h3, 4, 4, 0, 0, 0, 2'b00, TID, '0,
            0, 0, '0, 2, lat, nd, vi, sa, sw, gr, gs);
    checks++; if (vi !== 0 || lat !== 7) begin errors++; $display("FAIL ignore_pulse_txn: got lat %0d viol %0d expected 7 0", lat, vi); end
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      checks++;
      if ({o_busy, awvalid, wvalid, arvalid} !== 4'b0) begin
        errors++; $display("FAIL ignore_pulse_idle: got %b expected 0000", {o_busy, awvalid, wvalid, arvalid});
      end
    end
  endtask

  task automatic test_reset_mid_write();
    int lat, nd, vi; logic [31:0] sa, sw, gr; logic [1:0] gs;
    i_req = 1'b1; i_write = 1'b1; i_addr = 32'h0000_0500; i_wdata = 32'h55;
    @(negedge clk);
    i_req = 1'b0;
    checks++; if (awvalid !== 1'b1) begin errors++; $display("FAIL rstmid_pre: got awvalid %b expected 1", awvalid); end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({awvalid, wvalid, arvalid, bready, rready, o_busy} !== 6'b0) begin
      errors++; $display("FAIL rstmid_async: got %b expected 000000", {awvalid, wvalid, arvalid, bready, rready, o_busy});
    end
    @(negedge clk);
    rst_n = 1'b1;
    exp_rdata = '0;
    run_txn(0, 32'h0000_0600, '0, 0, 0, 0, 0, 0, 2'b00, TID, 32'h600D_0600,
            0, 0, '0, 0, lat, nd, vi, sa, sw, gr, gs);
    exp_rdata = 32'h600D_0600;
    checks++;
    if (lat !== 3 || gr !== 32'h600D_0600 || vi !== 0) begin
      errors++; $display("FAIL rstmid_after: got lat %0d data %h viol %0d expected 3 600d0600 0", lat, gr, vi);
    end
  endtask

  task automatic test_random();
    int lat, nd, vi, awd, wdd, bd, ard, rd, exp_lat;
    logic [31:0] sa, sw, gr, addr, wd, srd; logic [1:0] gs, sresp, exp_resp; logic [3:0] sid; bit wr;
    for (int n = 0; n < 40; n++) begin
      wr = 1'($urandom); addr = $urandom; wd = $urandom; srd = $urandom;
      awd = $urandom_range(0, 4); wdd = $urandom_range(0, 4); bd = $urandom_range(0, 3);
      ard = $urandom_range(0, 4); rd = $urandom_range(0, 3);
      sresp = 2'($urandom_range(0, 3));
      sid = ($urandom_range(0, 3) == 0) ? TID + 4'($urandom_range(1, 15)) : TID;
      run_txn(wr, addr, wd, awd, wdd, bd, ard, rd, sresp, sid, srd,
              0, 0, '0, 0, lat, nd, vi, sa, sw, gr, gs);
      exp_lat  = wr ? 3 + ((awd > wdd) ? awd : wdd) + bd : 3 + ard + rd;
      exp_resp = (sid == TID) ? sresp : 2'b10;
      if (!wr) exp_rdata = srd;
      checks++; if (lat !== exp_lat) begin errors++; $display("FAIL rnd%0d_lat: got %0d expected %0d", n, lat, exp_lat); end
      checks++; if (gs !== exp_resp) begin errors++; $display("FAIL rnd%0d_resp: got %b expected %b", n, gs, exp_resp); end
      checks++; if (gr !== exp_rdata) begin errors++; $display("FAIL rnd%0d_rdata: got %h expected %h", n, gr, exp_rdata); end
      checks++; if (sa !== (addr & 32'hFFFF_FFFC)) begin errors++; $display("FAIL rnd%0d_addr: got %h expected %h", n, sa, addr & 32'hFFFF_FFFC); end
      checks++; if (wr && sw !== wd) begin errors++; $display("FAIL rnd%0d_wdata: got %h expected %h", n, sw, wd); end
      checks++; if (vi !== 0) begin errors++; $display("FAIL rnd%0d_proto: got %0d violations expected 0", n, vi); end
    end
  endtask

  initial begin
    test_reset();
    test_write_zero_wait();
    test_read_stall();
    test_split_aw_w();
    test_responses();
    test_back_to_back();
    test_reset_mid_write();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
